led_fade_ctrl: RTL

Controller that sequences the LED sigma-delta intensity datapath on the TinyFPGA BX. It accepts target-intensity requests over a valid/ready handshake and ramps the 4-bit duty level one step per prescaled tick. It also provides an autonomous "breathe" mode and drives the LED pin through an internal first-order sigma-delta modulator.

---
 rtl/led_fade_ctrl_pkg.sv | 24 ++
 rtl/led_sd_mod.sv | 27 ++
 rtl/led_fade_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/led_fade_ctrl_pkg.sv
// Shared types and constants for the LED fade controller.
// Optional macro: LED_FADE_GAMMA_EN (gamma-corrected modulator duty).
package led_fade_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN,
        BR_UP,
        BR_DOWN
    } fade_state_t;

    localparam int          LEVEL_W_DEF = 4;
    localparam logic [3:0]  LEVEL_MAX   = 4'd15;

    // Perceptual gamma curve, entry i at [i].
    localparam logic [15:0][3:0] GAMMA_LUT = {
        4'd15, 4'd12, 4'd10, 4'd8,
        4'd6,  4'd5,  4'd4,  4'd3,
        4'd2,  4'd2,  4'd1,  4'd1,
        4'd1,  4'd0,  4'd0,  4'd0
    };

endpackage

// File: rtl/led_sd_mod.sv
// First-order sigma-delta modulator driving the LED pin.
// The carry out of the accumulator is the LED bit.
module led_sd_mod
    import led_fade_ctrl_pkg::*;
#(
    parameter int LEVEL_W = LEVEL_W_DEF
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [LEVEL_W-1:0] DUTY,
    output logic               LED
);

    logic [LEVEL_W:0] r_acc;

    // Accumulate duty; the carry bit is emitted and then dropped.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_acc <= '0;
        end else begin
            r_acc <= {1'b0, r_acc[LEVEL_W-1:0]} + {1'b0, DUTY};
        end
    end

    assign LED = r_acc[LEVEL_W];

endmodule

// File: rtl/led_fade_ctrl.sv
// LED intensity sequencer: handshake ramps, breathe mode, SD output.
// Optional macro: LED_FADE_GAMMA_EN (registered gamma table on duty).
module led_fade_ctrl
    import led_fade_ctrl_pkg::*;
#(
    parameter int STEP_DIV = 16000,
    parameter int LEVEL_W  = LEVEL_W_DEF
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [LEVEL_W-1:0] TGT_LEVEL,
    input  logic               TGT_VALID,
    output logic               TGT_READY,
    input  logic               MODE_BREATHE,
    output logic [LEVEL_W-1:0] LEVEL,
    output logic               BUSY,
    output logic               LED
);

    localparam int PW = $clog2(STEP_DIV);
    localparam logic [LEVEL_W-1:0] L_MAX = {LEVEL_W{1'b1}};
    localparam logic [PW-1:0] P_LAST = PW'(STEP_DIV - 1);

    fade_state_t        r_state;
    logic [LEVEL_W-1:0] r_level;
    logic [LEVEL_W-1:0] r_target;
    logic [PW-1:0]      r_presc;
    logic               r_ready;
    logic               r_busy;

    logic               w_tick;
    logic [LEVEL_W-1:0] w_inc;
    logic [LEVEL_W-1:0] w_dec;
    logic [LEVEL_W-1:0] w_duty;

    assign w_tick = (r_presc == P_LAST);
    assign w_inc  = r_level + 1'b1;
    assign w_dec  = r_level - 1'b1;

    // Sequencer: handshake, ramp and breathe stepping on prescaled ticks.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= IDLE;
            r_level  <= '0;
            r_target <= '0;
            r_presc  <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            unique case (r_state)
                IDLE: begin
                    r_presc <= '0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    if (TGT_VALID && r_ready) begin
                        r_target <= TGT_LEVEL;
                        if (TGT_LEVEL > r_level) begin
                            r_state <= RAMP_UP;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                        end else if (TGT_LEVEL < r_level) begin
                            r_state <= RAMP_DOWN;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end else if (MODE_BREATHE) begin
                        r_state <= (r_level == L_MAX) ? BR_DOWN : BR_UP;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                RAMP_UP: begin
                    if (w_tick) begin
                        r_level <= w_inc;
                        if (w_inc == r_target) begin
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (w_tick) begin
                        r_level <= w_dec;
                        if (w_dec == r_target) begin
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                BR_UP: begin
                    if (!MODE_BREATHE) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_tick) begin
                        r_level <= w_inc;
                        if (w_inc == L_MAX) r_state <= BR_DOWN;
                    end
                end
                BR_DOWN: begin
                    if (!MODE_BREATHE) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_tick) begin
                        r_level <= w_dec;
                        if (w_dec == '0) r_state <= BR_UP;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LED_FADE_GAMMA_EN
    logic [LEVEL_W-1:0] r_duty;

    // Gamma lookup is registered, so duty trails LEVEL by one cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_duty <= '0;
        end else begin
            r_duty <= LEVEL_W'(GAMMA_LUT[r_level[3:0]]);
        end
    end

    assign w_duty = r_duty;
`else
    assign w_duty = r_level;
`endif

    led_sd_mod #(
        .LEVEL_W (LEVEL_W)
    ) u_sd (
        .CLK   (CLK),
        .RST_N (RST_N),
        .DUTY  (w_duty),
        .LED   (LED)
    );

    assign TGT_READY = r_ready;
    assign BUSY      = r_busy;
    assign LEVEL     = r_level;

endmodule
